serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Parametrised bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop, processing one bit per clock.
//  Takes two WIDTH-bit operands on a start pulse and returns sum, carry-out and signed overflow after WIDTH clocks.
//  Used where area matters more than latency; successor to the combinational half adder (adds carry-in, width, mode, handshake).
// PARAMETERS
//  WIDTH  8  operand/result width in bits, 1..32
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous active-high reset
//  start     in   1      1-cycle request; samples a, b, sub
//  sub       in   1      0 = a+b, 1 = a-b
//  a         in   WIDTH  operand A (unsigned or two's complement)
//  b         in   WIDTH  operand B
//  busy      out  1      high while bits are being processed
//  done      out  1      1-cycle pulse: results valid
//  sum       out  WIDTH  result, held until next accepted start
//  carry     out  1      carry-out of MSB (sub: 1 = no borrow)
//  overflow  out  1      signed overflow (carry into MSB xor carry out of MSB)
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation): state=IDLE; busy, done, sum, carry, overflow = 0; internal shift regs, counter, carry FF = 0.
//  - States: IDLE, SHIFT, DONE.
//  - IDLE: start=1 -> latch A<=a, B<=(sub ? ~b : b), cy<=sub, cnt<=0, sum<=0; go SHIFT next edge.
//  - SHIFT (busy=1): per edge: s=A[0]^B[0]^cy; cy<=majority(A[0],B[0],cy); A,B shift right 1; s shifted into result MSB (result shifts right);
//    cnt<=cnt+1. On the edge where cnt==WIDTH-1: capture carry-into-MSB (old cy) for overflow, go DONE.
//  - DONE: done=1 for exactly one cycle; sum/carry/overflow valid; busy=0. Next: start=1 -> accept as from IDLE (back-to-back), else IDLE.
//  - Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH (done visible WIDTH+1 cycles after start); throughput 1 op per WIDTH+1 cycles.
//  - start while busy=1: ignored; operands/result unaffected; no queueing.
//  - a, b, sub need only be stable at the start edge; later changes ignored.
//  - Outputs sum/carry/overflow hold last result in IDLE; sum updates during SHIFT (partial), consumers use it only on done.
//  - Counter width: smallest width holding WIDTH-1 (WIDTH=1: single SHIFT cycle).
//  - Arithmetic: results identical to combinational {carry,sum} = a + (sub ? ~b : b) + sub, modulo 2^WIDTH.
// TESTING
//  1. WIDTH=8, add 0x3C+0x25 -> done at start+9 cycles, sum=0x61, carry=0, overflow=0; busy high exactly 8 cycles.
//  2. add 0xFF+0x01 -> sum=0x00, carry=1, overflow=0; add 0x7F+0x01 -> sum=0x80, carry=0, overflow=1.
//  3. sub 0x10-0x20 -> sum=0xF0, carry=0, overflow=0; sub 0x80-0x01 -> sum=0x7F, carry=1, overflow=1.
//  4. start pulsed again 3 cycles into op (different a, b) -> ignored, first result correct; start held in DONE cycle -> second op accepted back-to-back.
//  5. rst asserted mid-SHIFT (between edges) -> all outputs 0 immediately, IDLE; new op after release correct.
//  6. WIDTH=1 and WIDTH=32: random 1000 ops each vs. behavioural model a+/-b, compare sum/carry/overflow on every done.

Source files
------------

// File: rtl/serial_addsub_if.sv
`default_nettype none
// ============================================================================
// Module : serial_addsub_if
// Brief  : Request/result bundle for the bit-serial adder/subtractor.
// Rev    : 1.0  initial release
// ============================================================================
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module : serial_addsub
// Brief  : Bit-serial add/subtract, one full-adder cell and a carry FF, LSB first.
// Rev    : 1.0  initial release
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input wire              clk,
  input wire              rst,
  serial_addsub_if.slave  bus
);
  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_cy_next;
  logic [WIDTH:0]   w_sum_ext;

  assign w_accept  = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last    = (r_cnt == CNT_LAST);
  assign w_s       = r_a[0] ^ r_b[0] ^ r_cy;
  assign w_cy_next = (r_a[0] & r_b[0]) | (r_a[0] & r_cy) | (r_b[0] & r_cy);
  // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
  assign w_sum_ext = {w_s, r_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_next = S_DONE;
      S_DONE:  w_state_next = bus.start ? S_SHIFT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
      r_a   <= bus.a;
      r_b   <= bus.sub ? ~bus.b : bus.b;
      r_cy  <= bus.sub;
      r_cnt <= '0;
      r_sum <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_cy  <= w_cy_next;
      r_cnt <= r_cnt + CW'(1);
      r_sum <= w_sum_ext[WIDTH:1];
      if (w_last) begin
        r_carry <= w_cy_next;
        r_ovf   <= r_cy ^ w_cy_next;
      end
    end
  end

  assign bus.busy     = (r_state == S_SHIFT);
  assign bus.done     = (r_state == S_DONE);
  assign bus.sum      = r_sum;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_addsub
// Brief  : Scoreboard bench for serial_addsub at WIDTH 8, 1 and 32.
// Rev    : 1.0  initial release
// ============================================================================
module tb_serial_addsub;
  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t q8[$];
  exp_t q1[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  if8 ();
  serial_addsub_if #(.WIDTH(1))  if1 ();
  serial_addsub_if #(.WIDTH(32)) if32 ();

  serial_addsub #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_addsub #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_addsub #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  task automatic mon(input string tag, input exp_t e, input logic [31:0] s,
                     input logic c, input logic v);
    chk({tag, "_sum"}, s, e.sum);
    chk({tag, "_carry"}, 32'(c), 32'(e.c));
    chk({tag, "_overflow"}, 32'(v), 32'(e.v));
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && if8.done) begin
      if (q8.size() == 0) fail_now("w8_unexpected_done");
      else mon("w8", q8.pop_front(), 32'(if8.sum), if8.carry, if8.overflow);
    end
  end

  always @(negedge clk) begin
    if (!rst && if1.done) begin
      if (q1.size() == 0) fail_now("w1_unexpected_done");
      else mon("w1", q1.pop_front(), 32'(if1.sum), if1.carry, if1.overflow);
    end
  end

  always @(negedge clk) begin
    if (!rst && if32.done) begin
      if (q32.size() == 0) fail_now("w32_unexpected_done");
      else mon("w32", q32.pop_front(), if32.sum, if32.carry, if32.overflow);
    end
  end

  task automatic drive(input int w, input logic st, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    case (w)
      1:       begin if1.start = st; if1.sub = s; if1.a = a[0]; if1.b = b[0]; end
      8:       begin if8.start = st; if8.sub = s; if8.a = a[7:0]; if8.b = b[7:0]; end
      default: begin if32.start = st; if32.sub = s; if32.a = a; if32.b = b; end
    endcase
  endtask

  function automatic logic [1:0] flags(input int w);  // {busy, done}
    case (w)
      1:       return {if1.busy, if1.done};
      8:       return {if8.busy, if8.done};
      default: return {if32.busy, if32.done};
    endcase
  endfunction

  // Issue one op and wait for its done; poke>0 fires a spurious start at that cycle.
  task automatic op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] es, input logic ec, input logic ev,
                    input int poke = 0, input bit imm = 0);
    int  n;
    int  nb;
    bit  seen;
    exp_t e;
    e.sum = es; e.c = ec; e.v = ev;
    case (w)
      1:       q1.push_back(e);
      8:       q8.push_back(e);
      default: q32.push_back(e);
    endcase
    if (!imm) @(negedge clk);
    drive(w, 1'b1, s, a, b);
    nb = 0;
    seen = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) drive(w, 1'b0, ~s, ~a, ~b);
      if (poke > 0 && n == poke)     drive(w, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      if (poke > 0 && n == poke + 1) drive(w, 1'b0, 1'b0, 32'h0, 32'h0);
      if (flags(w)[1]) nb++;
      if (flags(w)[0]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("done_timeout");
    else begin
      chk("latency", 32'(n), 32'(w + 1));
      chk("busy_cycles", 32'(nb), 32'(w));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 1'b0, 1'b0, 0, 0);
    drive(8, 1'b0, 1'b0, 0, 0);
    drive(32, 1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_outputs", {if8.busy, if8.done, if8.carry, if8.overflow, 20'h0, if8.sum}, 32'h0);
    rst = 1'b0;

    op(8, 1'b0, 32'h3C, 32'h25, 32'h61, 1'b0, 1'b0);
    op(8, 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0);
    op(8, 1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1);
    op(8, 1'b1, 32'h10, 32'h20, 32'hF0, 1'b0, 1'b0);
    op(8, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1);

    // Reset in the middle of an op: outputs clear without a clock edge.
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 32'hFF, 32'h00);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 32'h00, 32'h00);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(if8.busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs",
           {if8.busy, if8.done, if8.carry, if8.overflow, 20'h0, if8.sum}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {30'h0, if8.busy, if8.done}, 32'h0);
    op(8, 1'b0, 32'hC8, 32'h64, 32'h2C, 1'b1, 1'b0);

    // Spurious start mid-op, then back-to-back start in the done cycle.
    op(8, 1'b0, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0, 3);
    op(8, 1'b0, 32'h50, 32'h50, 32'hA0, 1'b0, 1'b1);
    op(8, 1'b1, 32'h05, 32'h07, 32'hFE, 1'b0, 1'b0, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("held_sum", {if8.done, 23'h0, if8.sum}, 32'h0000_00FE);

    op(1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    op(1, 1'b0, 32'h1, 32'h0, 32'h1, 1'b0, 1'b0);
    op(1, 1'b0, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1);
    op(1, 1'b1, 32'h0, 32'h1, 32'h1, 1'b0, 1'b1);
    op(1, 1'b1, 32'h1, 32'h1, 32'h0, 1'b1, 1'b0);
    op(1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b1);

    op(32, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    op(32, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    op(32, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op(32, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
    op(32, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q8.size() + q1.size() + q32.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
